// File: rtl/axi_s6_mem_responder.sv
// rtl/axi_s6_mem_responder.sv - AXI4 slave memory responder for the Slave 6 window (optional macro AXI_S6_BACKPRESSURE_EN)
module axi_s6_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_C000,
  parameter int          MEM_WORDS = 1024,
  parameter int          ID_W      = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready
);

  localparam int          IDX_W   = $clog2(MEM_WORDS);
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(MEM_WORDS) * 33'd4 - 33'd1;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [31:0] mem [0:MEM_WORDS-1];

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= LO_ADDR) && ({1'b0, a} <= HI_ADDR);
  endfunction

  // A beat is served only if in window, word-sized, and the burst shape is legal
  function automatic logic beat_ok(input logic [31:0] a, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (burst != 2'b10) || (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    return in_window(a) && (size == 3'b010) && (burst != 2'b11) && wrap_ok;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] mask;
    mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      2'b01:   next_addr = a + 32'd4;
      2'b10:   next_addr = (a & ~mask) | ((a + 32'd4) & mask);
      default: next_addr = a;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Ready throttle: zero unless the backpressure LFSR is built in
  logic bp_d;
`ifdef AXI_S6_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, advances every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    bp_d   = (lfsr_d[1:0] == 2'b00);
  end

  // LFSR state register, reseeded on reset
  always_ff @(posedge clk) begin
    if (!rstn) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign bp_d = 1'b0;
`endif

  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] aw_id_q, aw_id_d, bid_q, bid_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [7:0]      w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]      w_size_q, w_size_d;
  logic [1:0]      w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic            w_err_q, w_err_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic            mem_we, w_ok, w_last_beat, w_err_acc;

  // Write channel next-state: AW latch, W beat accounting, B hold
  always_comb begin
    w_state_d   = w_state_q;
    aw_id_d     = aw_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_size_d    = w_size_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    w_ok        = beat_ok(w_addr_q, w_len_q, w_size_q, w_burst_q);
    w_last_beat = (w_cnt_q == w_len_q);
    w_err_acc   = w_err_q | ~w_ok | (w_last_beat != wlast);
    case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        aw_id_d   = awid;
        w_addr_d  = awaddr;
        w_len_d   = awlen;
        w_size_d  = awsize;
        w_burst_d = awburst;
        w_cnt_d   = 8'd0;
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        mem_we  = w_ok && rstn;
        w_err_d = w_err_acc;
        if (w_last_beat || wlast) begin
          bid_d     = aw_id_q;
          bresp_d   = w_err_acc ? SLVERR : OKAY;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d  = w_cnt_q + 8'd1;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !bp_d;
    wready_d  = (w_state_d == W_DATA) && !bp_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM and its registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Byte-masked memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  r_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     r_addr_q, r_addr_d, rdata_q, rdata_d, r_ld_addr;
  logic [7:0]      r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_ld_len, r_ld_cnt;
  logic [2:0]      r_size_q, r_size_d, r_ld_size;
  logic [1:0]      r_burst_q, r_burst_d, r_ld_burst, rresp_q, rresp_d;
  logic            rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q, arready_d;
  logic            r_ld, r_ld_ok;

  // Read channel next-state: load a beat on AR or on each R handshake
  always_comb begin
    r_state_d  = r_state_q;
    rid_d      = rid_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_size_d   = r_size_q;
    r_burst_d  = r_burst_q;
    r_cnt_d    = r_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    r_ld       = 1'b0;
    r_ld_addr  = next_addr(r_addr_q, r_len_q, r_burst_q);
    r_ld_len   = r_len_q;
    r_ld_size  = r_size_q;
    r_ld_burst = r_burst_q;
    r_ld_cnt   = r_cnt_q + 8'd1;
    case (r_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        r_ld       = 1'b1;
        r_ld_addr  = araddr;
        r_ld_len   = arlen;
        r_ld_size  = arsize;
        r_ld_burst = arburst;
        r_ld_cnt   = 8'd0;
        rid_d      = arid;
        r_state_d  = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_ld = 1'b1;
          end
        end else if (!rvalid_q) begin
          rvalid_d = !bp_d;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_ld_ok = beat_ok(r_ld_addr, r_ld_len, r_ld_size, r_ld_burst);
    if (r_ld) begin
      r_addr_d  = r_ld_addr;
      r_len_d   = r_ld_len;
      r_size_d  = r_ld_size;
      r_burst_d = r_ld_burst;
      r_cnt_d   = r_ld_cnt;
      rdata_d   = r_ld_ok ? mem[word_idx(r_ld_addr)] : 32'd0;
      rresp_d   = r_ld_ok ? OKAY : SLVERR;
      rlast_d   = (r_ld_cnt == r_ld_len);
      rvalid_d  = !bp_d;
    end
    arready_d = (r_state_d == R_IDLE) && !bp_d;
  end

  // Read FSM and its registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;
  assign arready = arready_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_s6_mem_responder.sv
// tb/tb_axi_s6_mem_responder.sv - directed self-checking bench for axi_s6_mem_responder
module tb_axi_s6_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_data [16];
  logic [1:0]  exp_resp [16];
  logic [31:0] wr_data  [16];

  always #5 clk = ~clk;

  axi_s6_mem_responder dut (
    .clk(clk), .rstn(rstn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'b010; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    check_eq("aw_wait_ok", 32'(n < 50), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 50) begin tick(); n++; end
    check_eq("w_wait_ok", 32'(n < 50), 32'd1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [5:0] id, input logic [1:0] resp,
                         input int hold);
    int n = 0;
    bready = (hold == 0);
    while (!bvalid && n < 50) begin tick(); n++; end
    check_eq({tag, "_bwait_ok"}, 32'(n < 50), 32'd1);
    check_eq({tag, "_bid"}, 32'(bid), 32'(id));
    check_eq({tag, "_bresp"}, 32'(bresp), 32'(resp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq($sformatf("%s_bhold%0d", tag, i), 32'(bvalid), 32'd1);
      check_eq($sformatf("%s_awrdy%0d", tag, i), 32'(awready), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic wr_burst(input string tag, input logic [5:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input logic [1:0] resp);
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) w_beat(wr_data[i], 4'hF, i == int'(len));
    b_check(tag, id, resp, 0);
  endtask

  task automatic ar_start(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = 3'b010; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    check_eq("ar_wait_ok", 32'(n < 50), 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_beats(input string tag, input logic [5:0] id, input int first,
                         input logic [7:0] len);
    rready = 1'b1;
    for (int i = first; i <= int'(len); i++) begin
      int n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      check_eq($sformatf("%s_rwait%0d_ok", tag, i), 32'(n < 50), 32'd1);
      check_eq($sformatf("%s_rid%0d", tag, i), 32'(rid), 32'(id));
      check_eq($sformatf("%s_rdata%0d", tag, i), rdata, exp_data[i]);
      check_eq($sformatf("%s_rresp%0d", tag, i), 32'(rresp), 32'(exp_resp[i]));
      check_eq($sformatf("%s_rlast%0d", tag, i), 32'(rlast), 32'(i == int'(len)));
      tick();
    end
    rready = 1'b0;
    check_eq({tag, "_rvalid_done"}, 32'(rvalid), 32'd0);
  endtask

  task automatic rd_burst(input string tag, input logic [5:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    ar_start(id, addr, len, burst);
    check_eq({tag, "_r_first_lat"}, 32'(rvalid), 32'd1);
    r_beats(tag, id, 0, len);
  endtask

  initial begin
    rstn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) tick();

    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rlast", 32'(rlast), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_bresp", 32'(bresp), 32'd0);
    rstn = 1'b1;
    tick();
    check_eq("idle_awready", 32'(awready), 32'd1);
    check_eq("idle_arready", 32'(arready), 32'd1);
    check_eq("idle_wready", 32'(wready), 32'd0);

    // INCR 4-beat write then read back
    for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
    wr_burst("t1w", 6'd5, 32'h0000_C010, 8'd3, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'(i + 1); exp_resp[i] = 2'b00; end
    rd_burst("t1r", 6'd5, 32'h0000_C010, 8'd3, 2'b01);

    // Byte strobes over a zeroed word
    wr_data[0] = 32'h0;
    wr_burst("t2z", 6'd1, 32'h0000_C000, 8'd0, 2'b01, 2'b00);
    aw_send(6'd2, 32'h0000_C000, 8'd0, 2'b01);
    w_beat(32'hAABB_CCDD, 4'b0101, 1'b1);
    b_check("t2w", 6'd2, 2'b00, 0);
    exp_data[0] = 32'h00BB_00DD; exp_resp[0] = 2'b00;
    rd_burst("t2r", 6'd3, 32'h0000_C000, 8'd0, 2'b01);

    // INCR burst running off the top of the window
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33; wr_data[3] = 32'h44;
    wr_burst("t3w", 6'd7, 32'h0000_CFF8, 8'd3, 2'b01, 2'b10);
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h0; exp_data[3] = 32'h0;
    exp_resp[0] = 2'b00;  exp_resp[1] = 2'b00;  exp_resp[2] = 2'b10; exp_resp[3] = 2'b10;
    rd_burst("t3r", 6'd7, 32'h0000_CFF8, 8'd3, 2'b01);

    // WRAP len=3 from 0xC008 lands at C008, C00C, C000, C004
    wr_data[0] = 32'hA0; wr_data[1] = 32'hA1; wr_data[2] = 32'hA2; wr_data[3] = 32'hA3;
    wr_burst("t4w", 6'd9, 32'h0000_C008, 8'd3, 2'b10, 2'b00);
    exp_data[0] = 32'hA2; exp_data[1] = 32'hA3; exp_data[2] = 32'hA0; exp_data[3] = 32'hA1;
    for (int i = 0; i < 4; i++) exp_resp[i] = 2'b00;
    rd_burst("t4i", 6'd9, 32'h0000_C000, 8'd3, 2'b01);
    exp_data[0] = 32'hA0; exp_data[1] = 32'hA1; exp_data[2] = 32'hA2; exp_data[3] = 32'hA3;
    rd_burst("t4r", 6'd10, 32'h0000_C008, 8'd3, 2'b10);

    // WRAP len=2 is illegal: SLVERR and memory untouched
    wr_data[0] = 32'hDEAD; wr_data[1] = 32'hBEEF; wr_data[2] = 32'hF00D;
    wr_burst("t5w", 6'd11, 32'h0000_C000, 8'd2, 2'b10, 2'b10);
    for (int i = 0; i < 3; i++) begin exp_data[i] = 32'h0; exp_resp[i] = 2'b10; end
    rd_burst("t5r", 6'd11, 32'h0000_C000, 8'd2, 2'b10);
    exp_data[0] = 32'hA2; exp_resp[0] = 2'b00;
    rd_burst("t5k", 6'd12, 32'h0000_C000, 8'd0, 2'b01);

    // rready stall mid-burst keeps the beat stable
    ar_start(6'd13, 32'h0000_C010, 8'd3, 2'b01);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("t6_stall_rvalid%0d", i), 32'(rvalid), 32'd1);
      check_eq($sformatf("t6_stall_rdata%0d", i), rdata, 32'd2);
      check_eq($sformatf("t6_stall_rlast%0d", i), 32'(rlast), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'(i + 1); exp_resp[i] = 2'b00; end
    r_beats("t6r", 6'd13, 1, 8'd3);

    // bready held low keeps bvalid up and blocks new AW
    aw_send(6'd14, 32'h0000_C100, 8'd0, 2'b01);
    w_beat(32'h1234_5678, 4'hF, 1'b1);
    b_check("t7", 6'd14, 2'b00, 4);
    exp_data[0] = 32'h1234_5678; exp_resp[0] = 2'b00;
    rd_burst("t7r", 6'd14, 32'h0000_C100, 8'd0, 2'b01);

    // Reset during beat 2 of a 4-beat read
    ar_start(6'd15, 32'h0000_C010, 8'd3, 2'b01);
    rready = 1'b1;
    tick();
    check_eq("t8_beat2_rdata", rdata, 32'd2);
    rstn = 1'b0;
    tick();
    check_eq("t8_rst_rvalid", 32'(rvalid), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("t8_no_beat%0d", i), 32'(rvalid), 32'd0);
    end
    check_eq("t8_arready", 32'(arready), 32'd1);
    rready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_s6_mem_responder.md
Name: axi_s6_mem_responder

Overview:
- AXI4 slave memory responder directly downstream of the Slave 6 interface; drives all Slave 6 ready/response signals.
- Accepts write and read bursts from the NOC for window 0x0000_C000–0x0000_CFFF and backs them with a 1024 x 32-bit word memory.
- Independent write FSM (AW→W→B) and read FSM (AR→R); one outstanding transaction per direction.

Parameters:
- BASE_ADDR, 32'h0000_C000, first byte address of the window.
- MEM_WORDS, 1024, memory depth in 32-bit words; window size is MEM_WORDS*4 bytes.
- ID_W, 6, AXI ID width.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
awid/arid  in  ID_W  request ID
awaddr/araddr  in  32  byte address
awlen/arlen  in  8  beats-1
awsize/arsize  in  3  beat size (only 3'b010 legal)
awburst/arburst  in  2  FIXED=0, INCR=1, WRAP=2
awvalid/arvalid  in  1  address valid
awready/arready  out  1  address ready
wdata  in  32  write data
wstrb  in  4  byte strobes
wlast  in  1  last write beat
wvalid  in  1  write valid
wready  out  1  write ready
bid  out  ID_W  write response ID
bresp  out  2  OKAY=0, SLVERR=2
bvalid  out  1  response valid
bready  in  1  response ready
rid  out  ID_W  read ID
rdata  out  32  read data
rresp  out  2  OKAY=0, SLVERR=2
rlast  out  1  last read beat
rvalid  out  1  read valid
rready  in  1  read ready

Behaviour:
- Reset: all registered outputs are 0 and both FSMs go idle; memory contents are not cleared. Reset mid-burst abandons the burst with no B/R completion.
- Write FSM W_IDLE→W_DATA→W_RESP→W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, clear beat count and err flag, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the enabled bytes when the beat address is in the window and size is legal; otherwise err=1 and memory is untouched.
  - Leave W_DATA when beat count==len, with err|=(wlast==0). A wlast seen on an earlier beat sets err and also ends the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=err?SLVERR:OKAY. bvalid holds until bready, then W_IDLE. B is never issued before the last W beat.
- Address sequencing (shared by both FSMs):
  - FIXED: constant address.
  - INCR: +4 per beat, no wrap. Beats past BASE_ADDR+MEM_WORDS*4-1 are out of range and set SLVERR.
  - WRAP: len must be 1, 3, 7 or 15, otherwise the whole burst gets SLVERR. The address wraps within a (len+1)*4-byte aligned block.
- Read FSM R_IDLE→R_DATA→R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch fields and go to R_DATA.
  - First rvalid appears exactly 1 cycle after the AR handshake.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len).
  - rdata = mem[beat addr] when the beat is legal; otherwise rdata=0 and rresp=SLVERR.
  - rdata/rresp/rlast are stable while rvalid && !rready. On handshake the next beat loads in the same cycle, so back-to-back beats need no bubble. After the rlast handshake, go to R_IDLE.
- Simultaneous events:
  - Read and write channels run concurrently.
  - A read beat loaded in the same cycle as a write to the same word returns the old data.
  - AW and W may arrive in the same cycle. W beats before the AW handshake are not accepted (wready=0 in W_IDLE).
- Address index = (addr-BASE_ADDR)>>2; in range iff BASE_ADDR <= addr <= BASE_ADDR+MEM_WORDS*4-1.

Optional Feature:
- Macro: AXI_S6_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - While lfsr[1:0]==2'b00, awready, wready and arready are forced to 0 and rvalid is not raised for a newly loaded beat.
  - A rvalid that is already asserted is never dropped.
- Undefined: no LFSR; ready/valid timing exactly as in Behaviour.

Test Plan:
- AW id=5, addr 0xC010, len=3, INCR; W data 1,2,3,4 with wstrb=F → bvalid with bid=5, OKAY. AR same → rdata 1,2,3,4, rlast on beat 4, rresp OKAY.
- AW 0xC000 len=0; W 0xAABBCCDD wstrb=4'b0101 over prior 0 → read returns 0x00BB00DD.
- INCR len=3 at 0xCFF8 → beats 3–4 out of range: write gives bresp SLVERR with only 2 words written; read gives rdata 0 and SLVERR on beats 3–4.
- WRAP len=3 at 0xC008 → beat addresses 0xC008, 0xC00C, 0xC000, 0xC004. WRAP len=2 → SLVERR.
- Hold rready=0 for 5 cycles mid-burst → rdata/rlast stable. Hold bready=0 → bvalid held and awready stays 0 until B completes.
- Assert rstn=0 during beat 2 of a 4-beat read → next cycle rvalid=0, arready=1 after reset release, no further R beats.
